// File: rtl/century_clock_bcd.sv
// BCD time-of-day and Gregorian calendar counter with per-digit outputs.
// Seconds/minutes/hours ripple from en_s; the date advances only on pulse_h.
module century_clock_bcd #(
    parameter logic [15:0] RST_YEAR = 16'h2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_s,
    output logic [3:0] sec_unit,
    output logic [3:0] sec_ten,
    output logic [3:0] min_unit,
    output logic [3:0] min_ten,
    output logic [3:0] hour_unit,
    output logic [3:0] hour_ten,
    output logic [3:0] day_unit,
    output logic [1:0] day_ten,
    output logic [3:0] month_unit,
    output logic [1:0] month_ten,
    output logic [3:0] year_unit,
    output logic [3:0] year_ten,
    output logic [3:0] year_hund,
    output logic [3:0] year_thou
);

    // Day-advance strobe; the only link from the time chain to the date chain.
    logic pulse_h;

    logic sec_max, min_max, hour_max;
    logic min_inc, hour_inc;
    logic leap, is_feb, is_30, day_last, month_adv, year_inc;

    logic [3:0] sec_unit_d, sec_ten_d, min_unit_d, min_ten_d, hour_unit_d, hour_ten_d;
    logic [3:0] day_unit_d, month_unit_d;
    logic [1:0] day_ten_d, month_ten_d;
    logic [3:0] year_unit_d, year_ten_d, year_hund_d, year_thou_d;

    // Two-digit BCD divisible-by-4 test: even tens need 0/4/8, odd tens need 2/6.
    function automatic logic pair_div4(input logic [3:0] tens, input logic [3:0] units);
        logic r;
        if (tens[0] == 1'b0)
            r = (units == 4'd0) || (units == 4'd4) || (units == 4'd8);
        else
            r = (units == 4'd2) || (units == 4'd6);
        return r;
    endfunction

    // Carry chain of the time-of-day counter.
    assign sec_max  = (sec_ten == 4'd5) && (sec_unit == 4'd9);
    assign min_max  = (min_ten == 4'd5) && (min_unit == 4'd9);
    assign hour_max = (hour_ten == 4'd2) && (hour_unit == 4'd3);
    assign min_inc  = en_s & sec_max;
    assign hour_inc = min_inc & min_max;
    assign pulse_h  = hour_inc & hour_max;

    // Gregorian leap year from BCD digits; a 00 century falls back to the upper pair.
    assign leap = ((year_ten == 4'd0) && (year_unit == 4'd0)) ? pair_div4(year_thou, year_hund)
                                                               : pair_div4(year_ten, year_unit);

    // Month length classification and last-day detection.
    assign is_feb   = (month_ten == 2'd0) && (month_unit == 4'd2);
    assign is_30    = ((month_ten == 2'd0) && ((month_unit == 4'd4) || (month_unit == 4'd6) ||
                                               (month_unit == 4'd9))) ||
                      ((month_ten == 2'd1) && (month_unit == 4'd1));
    assign day_last = is_feb ? ((day_ten == 2'd2) && (day_unit == (leap ? 4'd9 : 4'd8)))
                             : ((day_ten == 2'd3) && (day_unit == (is_30 ? 4'd0 : 4'd1)));
    assign month_adv = pulse_h & day_last;
    assign year_inc  = month_adv & (month_ten == 2'd1) & (month_unit == 4'd2);

    // Next-state for every digit; all carries resolve within the cycle.
    always_comb begin
        sec_unit_d   = sec_unit;
        sec_ten_d    = sec_ten;
        min_unit_d   = min_unit;
        min_ten_d    = min_ten;
        hour_unit_d  = hour_unit;
        hour_ten_d   = hour_ten;
        day_unit_d   = day_unit;
        day_ten_d    = day_ten;
        month_unit_d = month_unit;
        month_ten_d  = month_ten;
        year_unit_d  = year_unit;
        year_ten_d   = year_ten;
        year_hund_d  = year_hund;
        year_thou_d  = year_thou;

        if (en_s) begin
            if (sec_unit == 4'd9) begin
                sec_unit_d = 4'd0;
                sec_ten_d  = (sec_ten == 4'd5) ? 4'd0 : sec_ten + 4'd1;
            end else begin
                sec_unit_d = sec_unit + 4'd1;
            end
        end

        if (min_inc) begin
            if (min_unit == 4'd9) begin
                min_unit_d = 4'd0;
                min_ten_d  = (min_ten == 4'd5) ? 4'd0 : min_ten + 4'd1;
            end else begin
                min_unit_d = min_unit + 4'd1;
            end
        end

        if (hour_inc) begin
            if (hour_max) begin
                hour_unit_d = 4'd0;
                hour_ten_d  = 4'd0;
            end else if (hour_unit == 4'd9) begin
                hour_unit_d = 4'd0;
                hour_ten_d  = hour_ten + 4'd1;
            end else begin
                hour_unit_d = hour_unit + 4'd1;
            end
        end

        if (pulse_h) begin
            if (day_last) begin
                day_unit_d = 4'd1;
                day_ten_d  = 2'd0;
            end else if (day_unit == 4'd9) begin
                day_unit_d = 4'd0;
                day_ten_d  = day_ten + 2'd1;
            end else begin
                day_unit_d = day_unit + 4'd1;
            end
        end

        if (month_adv) begin
            if (year_inc) begin
                month_unit_d = 4'd1;
                month_ten_d  = 2'd0;
            end else if (month_unit == 4'd9) begin
                month_unit_d = 4'd0;
                month_ten_d  = 2'd1;
            end else begin
                month_unit_d = month_unit + 4'd1;
            end
        end

        if (year_inc) begin
            if (year_unit != 4'd9) begin
                year_unit_d = year_unit + 4'd1;
            end else begin
                year_unit_d = 4'd0;
                if (year_ten != 4'd9) begin
                    year_ten_d = year_ten + 4'd1;
                end else begin
                    year_ten_d = 4'd0;
                    if (year_hund != 4'd9) begin
                        year_hund_d = year_hund + 4'd1;
                    end else begin
                        year_hund_d = 4'd0;
                        year_thou_d = (year_thou == 4'd9) ? 4'd0 : year_thou + 4'd1;
                    end
                end
            end
        end
    end

    // Digit registers; reset wins over any advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_unit   <= 4'd0;
            sec_ten    <= 4'd0;
            min_unit   <= 4'd0;
            min_ten    <= 4'd0;
            hour_unit  <= 4'd0;
            hour_ten   <= 4'd0;
            day_unit   <= 4'd1;
            day_ten    <= 2'd0;
            month_unit <= 4'd1;
            month_ten  <= 2'd0;
            year_unit  <= RST_YEAR[3:0];
            year_ten   <= RST_YEAR[7:4];
            year_hund  <= RST_YEAR[11:8];
            year_thou  <= RST_YEAR[15:12];
        end else begin
            sec_unit   <= sec_unit_d;
            sec_ten    <= sec_ten_d;
            min_unit   <= min_unit_d;
            min_ten    <= min_ten_d;
            hour_unit  <= hour_unit_d;
            hour_ten   <= hour_ten_d;
            day_unit   <= day_unit_d;
            day_ten    <= day_ten_d;
            month_unit <= month_unit_d;
            month_ten  <= month_ten_d;
            year_unit  <= year_unit_d;
            year_ten   <= year_ten_d;
            year_hund  <= year_hund_d;
            year_thou  <= year_thou_d;
        end
    end

endmodule

// File: tb/tb_century_clock_bcd.sv
// Directed bench for century_clock_bcd: one main instance at 2000 plus four
// instances reset to other years so century and wrap boundaries are reachable.
module tb_century_clock_bcd;

    logic clk = 1'b0;
    logic rst, en_s, rst_x, en_x;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    logic [3:0] sec_unit, sec_ten, min_unit, min_ten, hour_unit, hour_ten;
    logic [3:0] day_unit, month_unit, year_unit, year_ten, year_hund, year_thou;
    logic [1:0] day_ten, month_ten;

    century_clock_bcd #(.RST_YEAR(16'h2000)) dut (
        .clk(clk), .rst(rst), .en_s(en_s),
        .sec_unit(sec_unit), .sec_ten(sec_ten), .min_unit(min_unit), .min_ten(min_ten),
        .hour_unit(hour_unit), .hour_ten(hour_ten), .day_unit(day_unit), .day_ten(day_ten),
        .month_unit(month_unit), .month_ten(month_ten), .year_unit(year_unit),
        .year_ten(year_ten), .year_hund(year_hund), .year_thou(year_thou)
    );

    logic [27:0] d_date;
    logic [23:0] d_time;
    assign d_date = {day_ten, day_unit, month_ten, month_unit, year_thou, year_hund, year_ten, year_unit};
    assign d_time = {hour_ten, hour_unit, min_ten, min_unit, sec_ten, sec_unit};

    // Extra instances: index 0..3 reset to 1899, 2023, 2099, 9999.
    logic [3:0][27:0] x_date;
    logic [3:0][23:0] x_time;
    int x_year [4] = '{1899, 2023, 2099, 9999};

    century_clock_bcd #(.RST_YEAR(16'h1899)) u_1899 (
        .clk(clk), .rst(rst_x), .en_s(en_x),
        .sec_unit(x_time[0][3:0]), .sec_ten(x_time[0][7:4]), .min_unit(x_time[0][11:8]),
        .min_ten(x_time[0][15:12]), .hour_unit(x_time[0][19:16]), .hour_ten(x_time[0][23:20]),
        .day_unit(x_date[0][25:22]), .day_ten(x_date[0][27:26]), .month_unit(x_date[0][19:16]),
        .month_ten(x_date[0][21:20]), .year_unit(x_date[0][3:0]), .year_ten(x_date[0][7:4]),
        .year_hund(x_date[0][11:8]), .year_thou(x_date[0][15:12])
    );
    century_clock_bcd #(.RST_YEAR(16'h2023)) u_2023 (
        .clk(clk), .rst(rst_x), .en_s(en_x),
        .sec_unit(x_time[1][3:0]), .sec_ten(x_time[1][7:4]), .min_unit(x_time[1][11:8]),
        .min_ten(x_time[1][15:12]), .hour_unit(x_time[1][19:16]), .hour_ten(x_time[1][23:20]),
        .day_unit(x_date[1][25:22]), .day_ten(x_date[1][27:26]), .month_unit(x_date[1][19:16]),
        .month_ten(x_date[1][21:20]), .year_unit(x_date[1][3:0]), .year_ten(x_date[1][7:4]),
        .year_hund(x_date[1][11:8]), .year_thou(x_date[1][15:12])
    );
    century_clock_bcd #(.RST_YEAR(16'h2099)) u_2099 (
        .clk(clk), .rst(rst_x), .en_s(en_x),
        .sec_unit(x_time[2][3:0]), .sec_ten(x_time[2][7:4]), .min_unit(x_time[2][11:8]),
        .min_ten(x_time[2][15:12]), .hour_unit(x_time[2][19:16]), .hour_ten(x_time[2][23:20]),
        .day_unit(x_date[2][25:22]), .day_ten(x_date[2][27:26]), .month_unit(x_date[2][19:16]),
        .month_ten(x_date[2][21:20]), .year_unit(x_date[2][3:0]), .year_ten(x_date[2][7:4]),
        .year_hund(x_date[2][11:8]), .year_thou(x_date[2][15:12])
    );
    century_clock_bcd #(.RST_YEAR(16'h9999)) u_9999 (
        .clk(clk), .rst(rst_x), .en_s(en_x),
        .sec_unit(x_time[3][3:0]), .sec_ten(x_time[3][7:4]), .min_unit(x_time[3][11:8]),
        .min_ten(x_time[3][15:12]), .hour_unit(x_time[3][19:16]), .hour_ten(x_time[3][23:20]),
        .day_unit(x_date[3][25:22]), .day_ten(x_date[3][27:26]), .month_unit(x_date[3][19:16]),
        .month_ten(x_date[3][21:20]), .year_unit(x_date[3][3:0]), .year_ten(x_date[3][7:4]),
        .year_hund(x_date[3][11:8]), .year_thou(x_date[3][15:12])
    );

    function automatic logic [27:0] bcd_date(input int d, input int m, input int y);
        return {2'(d / 10), 4'(d % 10), 2'(m / 10), 4'(m % 10),
                4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
    endfunction

    function automatic logic [23:0] bcd_time(input int s);
        int h, m, sc;
        h  = s / 3600;
        m  = (s / 60) % 60;
        sc = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic int days_in(input int m, input int y);
        if (m == 2) return (((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0)) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; rst_x = 1'b1; en_s = 1'b0; en_x = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0; rst_x = 1'b0;
    endtask

    task automatic pulse_dut(input int n);
        force dut.pulse_h = 1'b1;
        repeat (n) @(negedge clk);
        release dut.pulse_h;
    endtask

    task automatic pulse_all(input int n);
        force dut.pulse_h = 1'b1;
        force u_1899.pulse_h = 1'b1;
        force u_2023.pulse_h = 1'b1;
        force u_2099.pulse_h = 1'b1;
        force u_9999.pulse_h = 1'b1;
        repeat (n) @(negedge clk);
        release dut.pulse_h;
        release u_1899.pulse_h;
        release u_2023.pulse_h;
        release u_2099.pulse_h;
        release u_9999.pulse_h;
    endtask

    task automatic test_reset();
        do_reset(3);
        vectors++;
        if (d_time !== 24'h0) begin
            miscompares++; $display("FAIL reset_time: got %h expected %h", d_time, 24'h0);
        end
        vectors++;
        if (d_date !== bcd_date(1, 1, 2000)) begin
            miscompares++; $display("FAIL reset_date: got %h expected %h", d_date, bcd_date(1, 1, 2000));
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (x_date[k] !== bcd_date(1, 1, x_year[k])) begin
                miscompares++;
                $display("FAIL reset_date_x%0d: got %h expected %h", k, x_date[k], bcd_date(1, 1, x_year[k]));
            end
        end
        repeat (10) @(negedge clk);
        vectors++;
        if ({d_time, d_date} !== {24'h0, bcd_date(1, 1, 2000)}) begin
            miscompares++;
            $display("FAIL idle_hold: got %h expected %h", {d_time, d_date}, {24'h0, bcd_date(1, 1, 2000)});
        end
    endtask

    // Full day of ticks on dut; extras take a reset at 23:59:59 with the tick still high.
    task automatic test_day_rollover();
        int pulses, pulse_at;
        do_reset(1);
        pulses = 0; pulse_at = -1;
        en_s = 1'b1; en_x = 1'b1;
        for (int i = 0; i < 86400; i++) begin
            #1;
            if (i == 1 || i == 59 || i == 60 || i == 3599 || i == 3600 || i == 86399) begin
                vectors++;
                if (d_time !== bcd_time(i)) begin
                    miscompares++; $display("FAIL tick_time_%0d: got %h expected %h", i, d_time, bcd_time(i));
                end
            end
            if (dut.pulse_h) begin pulses++; pulse_at = i; end
            if (i == 86399) begin
                vectors++;
                if (u_2023.pulse_h !== 1'b1) begin
                    miscompares++; $display("FAIL x_pulse_at_235959: got %b expected 1", u_2023.pulse_h);
                end
                rst_x = 1'b1;
            end
            @(negedge clk);
        end
        en_s = 1'b0; en_x = 1'b0; rst_x = 1'b0;
        vectors++;
        if (pulses !== 1 || pulse_at !== 86399) begin
            miscompares++; $display("FAIL pulse_h_count: got %0d at %0d expected 1 at 86399", pulses, pulse_at);
        end
        vectors++;
        if ({d_time, d_date} !== {24'h0, bcd_date(2, 1, 2000)}) begin
            miscompares++;
            $display("FAIL day_rollover: got %h expected %h", {d_time, d_date}, {24'h0, bcd_date(2, 1, 2000)});
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if ({x_time[k], x_date[k]} !== {24'h0, bcd_date(1, 1, x_year[k])}) begin
                miscompares++;
                $display("FAIL rst_priority_x%0d: got %h expected %h", k, {x_time[k], x_date[k]},
                         {24'h0, bcd_date(1, 1, x_year[k])});
            end
        end
    endtask

    task automatic test_leap_2000();
        do_reset(1);
        pulse_dut(31);
        vectors++;
        if (d_date !== bcd_date(1, 2, 2000)) begin
            miscompares++; $display("FAIL jan_end: got %h expected %h", d_date, bcd_date(1, 2, 2000));
        end
        pulse_dut(28);
        vectors++;
        if (d_date !== bcd_date(29, 2, 2000)) begin
            miscompares++; $display("FAIL feb29_2000: got %h expected %h", d_date, bcd_date(29, 2, 2000));
        end
        pulse_dut(1);
        vectors++;
        if (d_date !== bcd_date(1, 3, 2000)) begin
            miscompares++; $display("FAIL mar1_2000: got %h expected %h", d_date, bcd_date(1, 3, 2000));
        end
        pulse_dut(60);
        vectors++;
        if (d_date !== bcd_date(30, 4, 2000)) begin
            miscompares++; $display("FAIL apr30: got %h expected %h", d_date, bcd_date(30, 4, 2000));
        end
        pulse_dut(1);
        vectors++;
        if ({d_time, d_date} !== {24'h0, bcd_date(1, 5, 2000)}) begin
            miscompares++;
            $display("FAIL may1: got %h expected %h", {d_time, d_date}, {24'h0, bcd_date(1, 5, 2000)});
        end
    endtask

    task automatic test_calendar_boundaries();
        do_reset(1);
        pulse_all(58);
        vectors++;
        if (x_date[1] !== bcd_date(28, 2, 2023)) begin
            miscompares++; $display("FAIL feb28_2023: got %h expected %h", x_date[1], bcd_date(28, 2, 2023));
        end
        pulse_all(1);
        vectors++;
        if (x_date[1] !== bcd_date(1, 3, 2023)) begin
            miscompares++; $display("FAIL mar1_2023: got %h expected %h", x_date[1], bcd_date(1, 3, 2023));
        end
        vectors++;
        if (d_date !== bcd_date(29, 2, 2000)) begin
            miscompares++; $display("FAIL feb29_2000_b: got %h expected %h", d_date, bcd_date(29, 2, 2000));
        end
        pulse_all(305);
        vectors++;
        if (x_date[2] !== bcd_date(31, 12, 2099)) begin
            miscompares++; $display("FAIL dec31_2099: got %h expected %h", x_date[2], bcd_date(31, 12, 2099));
        end
        vectors++;
        if (x_date[3] !== bcd_date(31, 12, 9999)) begin
            miscompares++; $display("FAIL dec31_9999: got %h expected %h", x_date[3], bcd_date(31, 12, 9999));
        end
        pulse_all(1);
        vectors++;
        if (x_date[2] !== bcd_date(1, 1, 2100)) begin
            miscompares++; $display("FAIL jan1_2100: got %h expected %h", x_date[2], bcd_date(1, 1, 2100));
        end
        vectors++;
        if (x_date[3] !== bcd_date(1, 1, 0)) begin
            miscompares++; $display("FAIL year_wrap: got %h expected %h", x_date[3], bcd_date(1, 1, 0));
        end
        vectors++;
        if (d_date !== bcd_date(31, 12, 2000)) begin
            miscompares++; $display("FAIL leap_year_len: got %h expected %h", d_date, bcd_date(31, 12, 2000));
        end
        pulse_all(58);
        vectors++;
        if ({x_date[0], x_date[1], x_date[2]} !==
            {bcd_date(28, 2, 1900), bcd_date(28, 2, 2024), bcd_date(28, 2, 2100)}) begin
            miscompares++;
            $display("FAIL feb28_set: got %h expected %h", {x_date[0], x_date[1], x_date[2]},
                     {bcd_date(28, 2, 1900), bcd_date(28, 2, 2024), bcd_date(28, 2, 2100)});
        end
        pulse_all(1);
        vectors++;
        if (x_date[0] !== bcd_date(1, 3, 1900)) begin
            miscompares++; $display("FAIL mar1_1900: got %h expected %h", x_date[0], bcd_date(1, 3, 1900));
        end
        vectors++;
        if (x_date[2] !== bcd_date(1, 3, 2100)) begin
            miscompares++; $display("FAIL mar1_2100: got %h expected %h", x_date[2], bcd_date(1, 3, 2100));
        end
        vectors++;
        if (x_date[1] !== bcd_date(29, 2, 2024)) begin
            miscompares++; $display("FAIL feb29_2024: got %h expected %h", x_date[1], bcd_date(29, 2, 2024));
        end
        pulse_all(1);
        vectors++;
        if (x_date[1] !== bcd_date(1, 3, 2024)) begin
            miscompares++; $display("FAIL mar1_2024: got %h expected %h", x_date[1], bcd_date(1, 3, 2024));
        end
    endtask

    // Four calendar years per instance, every pulse checked against a binary date model.
    task automatic test_model_sweep();
        int md [5];
        int mm [5];
        int my [5];
        int yrs [5] = '{2000, 1899, 2023, 2099, 9999};
        logic [27:0] got;
        do_reset(1);
        for (int k = 0; k < 5; k++) begin md[k] = 1; mm[k] = 1; my[k] = yrs[k]; end
        force dut.pulse_h = 1'b1;
        force u_1899.pulse_h = 1'b1;
        force u_2023.pulse_h = 1'b1;
        force u_2099.pulse_h = 1'b1;
        force u_9999.pulse_h = 1'b1;
        for (int p = 0; p < 1461; p++) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) begin
                md[k]++;
                if (md[k] > days_in(mm[k], my[k])) begin
                    md[k] = 1;
                    mm[k]++;
                    if (mm[k] > 12) begin mm[k] = 1; my[k] = (my[k] + 1) % 10000; end
                end
                got = (k == 0) ? d_date : x_date[k - 1];
                vectors++;
                if (got !== bcd_date(md[k], mm[k], my[k])) begin
                    miscompares++;
                    $display("FAIL sweep_u%0d_p%0d: got %h expected %h", k, p, got,
                             bcd_date(md[k], mm[k], my[k]));
                end
            end
        end
        release dut.pulse_h;
        release u_1899.pulse_h;
        release u_2023.pulse_h;
        release u_2099.pulse_h;
        release u_9999.pulse_h;
        vectors++;
        if (d_time !== 24'h0) begin
            miscompares++; $display("FAIL sweep_time_hold: got %h expected %h", d_time, 24'h0);
        end
    endtask

    initial begin
        rst = 1'b1; rst_x = 1'b1; en_s = 1'b0; en_x = 1'b0;
        test_reset();
        test_day_rollover();
        test_leap_2000();
        test_calendar_boundaries();
        test_model_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
